serial_adder_ctrl: RTL

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder. An accepted start captures A, B and carry-in. The single
//   full adder then processes one bit per clock, LSB first. After WIDTH bits
//   the registered sum/cout update and done pulses for one cycle.
//
//   Ports
//     clk    in   clock, rising edge
//     reset  in   asynchronous, active-high
//     start  in   begin an addition (accepted in IDLE or DONE)
//     a, b   in   operands, WIDTH bits, sampled on an accepted start
//     cin    in   carry-in, sampled on an accepted start
//     busy   out  high while bits are being processed (RUN)
//     done   out  one-cycle pulse, sum/cout freshly updated
//     sum    out  (A+B+cin) mod 2^WIDTH, held until the next completion
//     cout   out  bit WIDTH of A+B+cin
// -----------------------------------------------------------------------------

// 1-bit full adder shared by the serial datapath.
module full_adder (
    output logic sum,
    output logic cout,
    input  logic cin,
    input  logic a,
    input  logic b
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, psum_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, busy_q, done_q;

    logic             fa_s, fa_c;
    logic [WIDTH-1:0] psum_d;

    full_adder u_fa (
        .sum  (fa_s),
        .cout (fa_c),
        .cin  (carry_q),
        .a    (a_q[0]),
        .b    (b_q[0])
    );

    // New bit enters at the MSB, so after WIDTH shifts bit 0 holds the LSB.
    assign psum_d = {fa_s, psum_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here.
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= fa_c;
                    psum_q  <= psum_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        sum_q   <= psum_d;
                        cout_q  <= fa_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    // Back-to-back: a start here reloads with no idle bubble.
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule
